// File: rtl/vf_config_loader.sv
// vf_config_loader: fetches one configuration context (header + NUM_WORDS
// words) from BRAM into a shadow register and publishes it on cfg_bus in a
// single cycle, so the fabric never sees a partially loaded image.
module vf_config_loader #(
  parameter int unsigned NUM_WORDS = 22,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [15:0] MAGIC     = 16'hC0F1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    run,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic                    bram_en,
  input  logic [31:0]             bram_dout,
  output logic [32*NUM_WORDS-1:0] cfg_bus,
  output logic                    fabric_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned IMG_W = 32 * NUM_WORDS;

  typedef enum logic [2:0] {IDLE, HREQ, HCHK, LOAD, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_en_q, bram_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IMG_W-1:0]  shadow_q, shadow_d;
  logic [IMG_W-1:0]  cfg_q, cfg_d;
  logic              hdr_ok;

  assign hdr_ok = (bram_dout[31:16] == MAGIC) && (bram_dout[7:0] == 8'(NUM_WORDS));

  // Next-state, address issue and word capture.
  // In LOAD, cnt_q counts edges since entering LOAD: address cnt_q+1 is
  // issued while cnt_q < NUM_WORDS-1, and word cnt_q-1 arrives on bram_dout
  // (two-edge BRAM round trip), so issue and capture overlap without bubbles.
  always_comb begin
    state_d     = state_q;
    bram_addr_d = bram_addr_q;
    bram_en_d   = bram_en_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = HREQ;
          bram_addr_d = base_addr;
          bram_en_d   = 1'b1;
          err_d       = 1'b0;
        end
      end
      HREQ: begin
        state_d = HCHK;
      end
      HCHK: begin
        if (hdr_ok) begin
          state_d     = LOAD;
          bram_addr_d = bram_addr_q + ADDR_W'(1);
          cnt_d       = '0;
        end else begin
          state_d   = IDLE;
          bram_en_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(NUM_WORDS - 1)) begin
          bram_addr_d = bram_addr_q + ADDR_W'(1);
        end else begin
          bram_en_d = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          if (cnt_q == CNT_W'(i + 1)) begin
            shadow_d[32*i +: 32] = bram_dout;
          end
        end
        if (cnt_q == CNT_W'(NUM_WORDS)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cfg_d   = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and published-image registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cfg_q       <= '0;
    end else begin
      state_q     <= state_d;
      bram_addr_q <= bram_addr_d;
      bram_en_q   <= bram_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
    end
  end

  // Shadow image has no reset; it only reaches cfg_bus through COMMIT.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign bram_addr = bram_addr_q;
  assign bram_en   = bram_en_q;
  assign cfg_bus   = cfg_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign fabric_en = run & ~busy;

endmodule

// File: tb/tb_vf_config_loader.sv
// Directed bench for vf_config_loader with a behavioural one-cycle BRAM.
module tb_vf_config_loader;

  localparam int unsigned NW = 22;

  logic            clk;
  logic            rst;
  logic            start;
  logic [9:0]      base_addr;
  logic            run;
  logic [9:0]      bram_addr;
  logic            bram_en;
  logic [31:0]     bram_dout;
  logic [32*NW-1:0] cfg_bus;
  logic            fabric_en;
  logic            busy;
  logic            done;
  logic            err;

  logic [31:0] mem [1024];
  logic [31:0] exp_img [NW];
  int n_cmp;
  int n_err;

  vf_config_loader #(
    .NUM_WORDS(NW),
    .ADDR_W(10),
    .MAGIC(16'hC0F1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .run(run),
    .bram_addr(bram_addr),
    .bram_en(bram_en),
    .bram_dout(bram_dout),
    .cfg_bus(cfg_bus),
    .fabric_en(fabric_en),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM: data for the address sampled at an edge appears after it.
  always @(posedge clk) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  function automatic logic [32*NW-1:0] img_flat();
    logic [32*NW-1:0] f;
    for (int k = 0; k < NW; k++) f[32*k +: 32] = exp_img[k];
    return f;
  endfunction

  task automatic fill_ctx(input logic [9:0] base, input logic [31:0] hdr, input logic [31:0] dbase);
    logic [9:0] a;
    mem[base] = hdr;
    for (int k = 0; k < NW; k++) begin
      a = base + 10'(k + 1);
      mem[a] = dbase + 32'(k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cfg_bus !== '0 || bram_addr !== 10'h0 || bram_en !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: cfg_nz=%b addr=%h en=%b busy=%b done=%b err=%b required all zero",
               (cfg_bus != '0), bram_addr, bram_en, busy, done, err);
    end
    run = 1'b0;
    #1;
    n_cmp++;
    if (fabric_en !== 1'b0) begin
      n_err++;
      $display("FAIL fabric_run0: got %b required 0", fabric_en);
    end
    run = 1'b1;
    #1;
    n_cmp++;
    if (fabric_en !== 1'b1) begin
      n_err++;
      $display("FAIL fabric_run1: got %b required 1", fabric_en);
    end
    for (int k = 0; k < NW; k++) exp_img[k] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Full load from base; optionally pulses start with alt_base at E5.
  task automatic test_valid_load(input string name, input logic [9:0] base,
                                 input logic [31:0] dbase, input bit pulse_busy,
                                 input logic [9:0] alt_base);
    int done_at;
    logic [9:0] ea;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (bram_addr !== base || bram_en !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || fabric_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_e0: addr=%h en=%b busy=%b err=%b fab=%b required addr=%h en=1 busy=1 err=0 fab=0",
               name, bram_addr, bram_en, busy, err, fabric_en, base);
    end
    done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      if (pulse_busy && i == 5) begin
        start = 1'b1;
        base_addr = alt_base;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        done_at = i;
      end else begin
        n_cmp++;
        if (fabric_en !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s_busy_e%0d: fab=%b busy=%b required fab=0 busy=1", name, i, fabric_en, busy);
        end
        n_cmp++;
        if (cfg_bus !== img_flat()) begin
          n_err++;
          $display("FAIL %s_partial_e%0d: cfg_bus changed before commit, required previous image", name, i);
        end
        if (i >= 2 && i <= 23) begin
          ea = base + 10'(i - 1);
          n_cmp++;
          if (bram_addr !== ea || bram_en !== 1'b1) begin
            n_err++;
            $display("FAIL %s_addr_e%0d: addr=%h en=%b required addr=%h en=1", name, i, bram_addr, bram_en, ea);
          end
        end
        if (i == 24) begin
          n_cmp++;
          if (bram_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s_en_drop: en=%b required 0", name, bram_en);
          end
        end
      end
    end
    n_cmp++;
    if (done_at != 26) begin
      n_err++;
      $display("FAIL %s_latency: done after %0d edges required 26", name, done_at);
    end
    for (int k = 0; k < NW; k++) exp_img[k] = dbase + 32'(k);
    for (int k = 0; k < NW; k++) begin
      n_cmp++;
      if (cfg_bus[32*k +: 32] !== exp_img[k]) begin
        n_err++;
        $display("FAIL %s_slot%0d: got %h required %h", name, k, cfg_bus[32*k +: 32], exp_img[k]);
      end
    end
    n_cmp++;
    if (fabric_en !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL %s_after: fab=%b busy=%b err=%b required fab=1 busy=0 err=0", name, fabric_en, busy, err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_pulse: done=%b one cycle after, required 0", name, done);
    end
  endtask

  task automatic test_bad_header(input string name, input logic [9:0] base, input logic [31:0] hdr);
    mem[base] = hdr;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || err !== 1'b0 || fabric_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_e0: busy=%b err=%b fab=%b required busy=1 err=0 fab=0", name, busy, err, fabric_en);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || fabric_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_e1: busy=%b done=%b fab=%b required busy=1 done=0 fab=0", name, busy, done, fabric_en);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1 || bram_en !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_e2: done=%b err=%b en=%b busy=%b required done=1 err=1 en=0 busy=0",
               name, done, err, bram_en, busy);
    end
    n_cmp++;
    if (cfg_bus !== img_flat()) begin
      n_err++;
      $display("FAIL %s_image: cfg_bus changed, required previous image", name);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || err !== 1'b1 || bram_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_e3: done=%b err=%b en=%b required done=0 err=1 en=0", name, done, err, bram_en);
    end
  endtask

  task automatic test_reset_mid_load(input logic [9:0] base);
    int seen_done;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < NW; k++) exp_img[k] = 32'h0;
    n_cmp++;
    if (cfg_bus !== '0 || busy !== 1'b0 || done !== 1'b0 || bram_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: cfg_nz=%b busy=%b done=%b en=%b required 0 0 0 0",
               (cfg_bus != '0), busy, done, bram_en);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0 || cfg_bus !== '0) begin
      n_err++;
      $display("FAIL rst_quiet: done/busy seen %0d cycles, cfg_nz=%b required 0 and 0",
               seen_done, (cfg_bus != '0));
    end
  endtask

  task automatic test_back_to_back(input logic [9:0] b1, input logic [31:0] d1,
                                   input logic [9:0] b2, input logic [31:0] d2);
    int done_at;
    @(negedge clk);
    base_addr = b1;
    start = 1'b1;
    @(posedge clk); #1;
    base_addr = b2;
    done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_at = i;
    end
    n_cmp++;
    if (done_at != 26 || cfg_bus[32*3 +: 32] !== d1 + 32'd3) begin
      n_err++;
      $display("FAIL b2b_first: done after %0d slot3=%h required 26 and %h", done_at, cfg_bus[32*3 +: 32], d1 + 32'd3);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || bram_addr !== b2) begin
      n_err++;
      $display("FAIL b2b_restart: busy=%b done=%b addr=%h required busy=1 done=0 addr=%h", busy, done, bram_addr, b2);
    end
    done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_at = i;
    end
    n_cmp++;
    if (done_at != 26) begin
      n_err++;
      $display("FAIL b2b_latency: done after %0d required 26", done_at);
    end
    for (int k = 0; k < NW; k++) exp_img[k] = d2 + 32'(k);
    n_cmp++;
    if (cfg_bus !== img_flat()) begin
      n_err++;
      $display("FAIL b2b_image: slot0=%h slot21=%h required %h %h",
               cfg_bus[31:0], cfg_bus[32*21 +: 32], exp_img[0], exp_img[21]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    run = 1'b1;
    base_addr = 10'h0;
    #2;
    fill_ctx(10'h010, 32'hC0F10016, 32'hA0000000);
    fill_ctx(10'h080, 32'hC0F10016, 32'hB0000000);
    fill_ctx(10'h100, 32'hC0F10016, 32'hD0000000);
    fill_ctx(10'h200, 32'hC0F10016, 32'hE0000000);
    test_reset();
    test_valid_load("valid", 10'h010, 32'hA0000000, 1'b0, 10'h0);
    test_bad_header("bad_magic", 10'h040, 32'hBEEF0016);
    test_bad_header("bad_count", 10'h060, 32'hC0F10015);
    test_valid_load("after_err", 10'h080, 32'hB0000000, 1'b0, 10'h0);
    fill_ctx(10'h3FE, 32'hC0F10016, 32'hC0000000);
    test_valid_load("wrap", 10'h3FE, 32'hC0000000, 1'b0, 10'h0);
    test_valid_load("start_busy", 10'h100, 32'hD0000000, 1'b1, 10'h200);
    test_reset_mid_load(10'h200);
    test_valid_load("after_rst", 10'h100, 32'hD0000000, 1'b0, 10'h0);
    test_back_to_back(10'h080, 32'hB0000000, 10'h200, 32'hE0000000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
